// File: rtl/msk_rcon_sched.sv
// msk_rcon_sched: emits NROUNDS AES round constants (01,02,04,...) as
// bit-sliced d-share sharings over a valid/ready handshake, then pulses done.
// Optional build macro MSK_RCON_REFRESH_EN adds the rnd port and re-masks
// every presented sharing with fresh randomness; otherwise the sharing is
// the constant-injection form (rcon, 0, ..., 0).
module msk_rcon_sched #(
  parameter int d       = 2,
  parameter int NROUNDS = 10,
  parameter int count   = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic [7:0]               round_idx,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [count*d-1:0]       out
`ifdef MSK_RCON_REFRESH_EN
  ,
  input  logic [count*(d-1)-1:0]   rnd
`endif
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIN  = 2'd2;

  localparam logic [7:0] RCON_INIT = 8'h01;
  localparam logic [7:0] LAST_IDX  = 8'(NROUNDS - 1);

  logic [1:0]             state_q, state_d;
  logic [7:0]             rcon_q, rcon_d;
  logic [7:0]             round_idx_q, round_idx_d;
  logic [count*d-1:0]     out_q, out_d;
  logic [count*(d-1)-1:0] mask_bits;
  logic [7:0]             rcon_next;

`ifdef MSK_RCON_REFRESH_EN
  assign mask_bits = rnd;
`else
  assign mask_bits = '0;
`endif

  // GF(2^8) doubling modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1B : 8'h00);
  endfunction

  // Bit-sliced sharing: shares 1..d-1 take the mask bits, share 0 absorbs
  // the constant so that the XOR of all shares of bit i equals v[i].
  function automatic logic [count*d-1:0] make_sharing(
    input logic [7:0]             v,
    input logic [count*(d-1)-1:0] r
  );
    logic [count*d-1:0] s;
    logic               acc;
    s = '0;
    for (int unsigned i = 0; i < count; i++) begin
      acc = v[i];
      for (int unsigned j = 1; j < d; j++) begin
        s[i*d+j] = r[i*(d-1)+j-1];
        acc      = acc ^ r[i*(d-1)+j-1];
      end
      s[i*d] = acc;
    end
    return s;
  endfunction

  assign rcon_next = xtime(rcon_q);

  // Next-state logic: sharing is only rebuilt on run start and on non-final
  // handshakes, so it (and the sampled mask) holds across stalls.
  always_comb begin
    state_d     = state_q;
    rcon_d      = rcon_q;
    round_idx_d = round_idx_q;
    out_d       = out_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_RUN;
          rcon_d      = RCON_INIT;
          round_idx_d = '0;
          out_d       = make_sharing(RCON_INIT, mask_bits);
        end
      end
      ST_RUN: begin
        if (out_ready) begin
          if (round_idx_q == LAST_IDX) begin
            state_d = ST_FIN;
            out_d   = '0;
          end else begin
            rcon_d      = rcon_next;
            round_idx_d = round_idx_q + 8'd1;
            out_d       = make_sharing(rcon_next, mask_bits);
          end
        end
      end
      ST_FIN: begin
        state_d     = ST_IDLE;
        rcon_d      = RCON_INIT;
        round_idx_d = '0;
        out_d       = '0;
      end
      default: begin
        state_d     = ST_IDLE;
        rcon_d      = RCON_INIT;
        round_idx_d = '0;
        out_d       = '0;
      end
    endcase
  end

  // State registers with asynchronous abort to the idle values
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rcon_q      <= RCON_INIT;
      round_idx_q <= '0;
      out_q       <= '0;
    end else begin
      state_q     <= state_d;
      rcon_q      <= rcon_d;
      round_idx_q <= round_idx_d;
      out_q       <= out_d;
    end
  end

  assign busy      = (state_q == ST_RUN);
  assign out_valid = (state_q == ST_RUN);
  assign done      = (state_q == ST_FIN);
  assign round_idx = round_idx_q;
  assign out       = out_q;

endmodule

// File: tb/tb_msk_rcon_sched.sv
// Self-checking bench for msk_rcon_sched. Two instances: NROUNDS=10 (main
// scenarios) and NROUNDS=14 (GF(2^8) wrap). With MSK_RCON_REFRESH_EN the
// instances use d=3 and random masks.
module tb_msk_rcon_sched;

`ifdef MSK_RCON_REFRESH_EN
  localparam int D = 3;
`else
  localparam int D = 2;
`endif
  localparam int W  = 8 * D;
  localparam int RW = 8 * (D - 1);

  localparam logic [7:0] RCON10 [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                         8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};
  localparam logic [7:0] RCON14 [14] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                         8'h20, 8'h40, 8'h80, 8'h1B, 8'h36,
                                         8'h6C, 8'hD8, 8'hAB, 8'h4D};

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start_a = 1'b0, ready_a = 1'b0;
  logic         busy_a, done_a, valid_a;
  logic [7:0]   idx_a;
  logic [W-1:0] out_a;
  logic         start_b = 1'b0, ready_b = 1'b0;
  logic         busy_b, done_b, valid_b;
  logic [7:0]   idx_b;
  logic [W-1:0] out_b;
`ifdef MSK_RCON_REFRESH_EN
  logic [RW-1:0] rnd_a = '0, rnd_b = '0;
`endif
  logic [RW-1:0] rnd_lat_a = '0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  msk_rcon_sched #(.d(D), .NROUNDS(10), .count(8)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .busy(busy_a), .done(done_a),
    .round_idx(idx_a), .out_valid(valid_a), .out_ready(ready_a), .out(out_a)
`ifdef MSK_RCON_REFRESH_EN
    , .rnd(rnd_a)
`endif
  );

  msk_rcon_sched #(.d(D), .NROUNDS(14), .count(8)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b),
    .round_idx(idx_b), .out_valid(valid_b), .out_ready(ready_b), .out(out_b)
`ifdef MSK_RCON_REFRESH_EN
    , .rnd(rnd_b)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] recombine(input logic [W-1:0] s);
    logic [7:0] v;
    v = '0;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < D; j++)
        v[i] = v[i] ^ s[i*D+j];
    return v;
  endfunction

  // Expected full sharing: shares 1..D-1 are the latched mask (zero in the
  // default build), share 0 makes the per-bit XOR equal the constant.
  function automatic logic [W-1:0] expect_vec(input logic [7:0] v, input logic [RW-1:0] r);
    logic [W-1:0] s;
    logic         b;
    s = '0;
    for (int i = 0; i < 8; i++) begin
      b = v[i];
      for (int j = 1; j < D; j++) begin
        s[i*D+j] = r[i*(D-1)+j-1];
        b = b ^ r[i*(D-1)+j-1];
      end
      s[i*D] = b;
    end
    return s;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    tick();
    checks += 5;
    if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy_a); end
    if (done_a !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done_a); end
    if (valid_a !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid_a); end
    if (idx_a !== 8'd0) begin errors++; $display("FAIL reset_idx: got %0d expected 0", idx_a); end
    if (out_a !== '0) begin errors++; $display("FAIL reset_out: got %h expected 0", out_a); end
    rst = 1'b0;
    tick();
  endtask

  // One full run on dut_a with optional stall and optional stray starts.
  // Expected constants are queued at start and popped on each handshake.
  task automatic run_a(input int stall_at, input int stall_len, input bit poke_starts);
    logic [7:0]   q[$];
    logic [W-1:0] prev_out;
    int           idx, stalled;
    bit           last, prev_stall, rdy;
    idx = 0; stalled = 0; last = 0; prev_stall = 0; prev_out = '0;
    for (int k = 0; k < 10; k++) q.push_back(RCON10[k]);
    ready_a = 1'b1;
    start_a = 1'b1;
`ifdef MSK_RCON_REFRESH_EN
    rnd_a = RW'($urandom);
    rnd_lat_a = rnd_a;
`endif
    tick();
    start_a = 1'b0;
    for (int c = 0; c < 100 && !last; c++) begin
      checks += 5;
      if (valid_a !== 1'b1 || busy_a !== 1'b1) begin
        errors++; $display("FAIL run_valid_busy: got %b/%b expected 1/1", valid_a, busy_a);
      end
      if (done_a !== 1'b0) begin errors++; $display("FAIL run_done_early: got %b expected 0", done_a); end
      if (idx_a !== 8'(idx)) begin errors++; $display("FAIL run_idx: got %0d expected %0d", idx_a, idx); end
      if (recombine(out_a) !== q[0]) begin
        errors++; $display("FAIL run_const: got %h expected %h", recombine(out_a), q[0]);
      end
      if (out_a !== expect_vec(q[0], rnd_lat_a)) begin
        errors++; $display("FAIL run_shares: got %h expected %h", out_a, expect_vec(q[0], rnd_lat_a));
      end
      if (prev_stall) begin
        checks++;
        if (out_a !== prev_out) begin errors++; $display("FAIL stall_hold: got %h expected %h", out_a, prev_out); end
      end
      rdy = !(idx == stall_at && stalled < stall_len);
      if (!rdy) stalled++;
      ready_a = rdy;
      start_a = poke_starts && (idx == 2);
`ifdef MSK_RCON_REFRESH_EN
      rnd_a = RW'($urandom);
`endif
      if (rdy) begin
        void'(q.pop_front());
        if (idx == 9) last = 1;
        else begin
`ifdef MSK_RCON_REFRESH_EN
          rnd_lat_a = rnd_a;
`endif
          idx++;
        end
      end
      prev_out = out_a;
      prev_stall = !rdy;
      tick();
      start_a = 1'b0;
    end
    checks++;
    if (!last || q.size() != 0) begin
      errors++; $display("FAIL run_timeout: got %0d left expected 0", q.size());
    end
    checks += 3;
    if (done_a !== 1'b1) begin errors++; $display("FAIL fin_done: got %b expected 1", done_a); end
    if (busy_a !== 1'b0) begin errors++; $display("FAIL fin_busy: got %b expected 0", busy_a); end
    if (valid_a !== 1'b0) begin errors++; $display("FAIL fin_valid: got %b expected 0", valid_a); end
    start_a = poke_starts;
    tick();
    start_a = 1'b0;
    for (int c = 0; c < 3; c++) begin
      checks += 3;
      if (done_a !== 1'b0) begin errors++; $display("FAIL idle_done: got %b expected 0", done_a); end
      if (valid_a !== 1'b0) begin errors++; $display("FAIL idle_valid: got %b expected 0", valid_a); end
      if (idx_a !== 8'd0) begin errors++; $display("FAIL idle_idx: got %0d expected 0", idx_a); end
      tick();
    end
  endtask

  task automatic test_stream();       run_a(-1, 0, 0); endtask
  task automatic test_backpressure(); run_a(3, 5, 0);  endtask

  task automatic test_ignored_start();
    run_a(-1, 0, 1);
    run_a(-1, 0, 0);
  endtask

  task automatic test_rst_mid();
    int c;
    ready_a = 1'b1;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    c = 0;
    while (idx_a !== 8'd5 && c < 50) begin tick(); c++; end
    checks++;
    if (idx_a !== 8'd5) begin errors++; $display("FAIL rst_reach5: got %0d expected 5", idx_a); end
    rst = 1'b1;
    #1;
    checks += 4;
    if (valid_a !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", valid_a); end
    if (busy_a !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy_a); end
    if (out_a !== '0) begin errors++; $display("FAIL rst_out: got %h expected 0", out_a); end
    if (idx_a !== 8'd0) begin errors++; $display("FAIL rst_idx: got %0d expected 0", idx_a); end
    tick();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (done_a !== 1'b0) begin errors++; $display("FAIL rst_no_done: got %b expected 0", done_a); end
    end
    run_a(-1, 0, 0);
  endtask

  task automatic test_refresh_stalls();
    run_a(4, 3, 0);
    run_a(8, 2, 0);
  endtask

  task automatic test_wrap();
    ready_b = 1'b1;
    start_b = 1'b1;
`ifdef MSK_RCON_REFRESH_EN
    rnd_b = RW'($urandom);
`endif
    tick();
    start_b = 1'b0;
    for (int k = 0; k < 14; k++) begin
      checks += 3;
      if (valid_b !== 1'b1) begin errors++; $display("FAIL wrap_valid: got %b expected 1", valid_b); end
      if (idx_b !== 8'(k)) begin errors++; $display("FAIL wrap_idx: got %0d expected %0d", idx_b, k); end
      if (recombine(out_b) !== RCON14[k]) begin
        errors++; $display("FAIL wrap_const: got %h expected %h", recombine(out_b), RCON14[k]);
      end
`ifdef MSK_RCON_REFRESH_EN
      rnd_b = RW'($urandom);
`endif
      tick();
    end
    checks += 2;
    if (done_b !== 1'b1) begin errors++; $display("FAIL wrap_done: got %b expected 1", done_b); end
    if (valid_b !== 1'b0) begin errors++; $display("FAIL wrap_fin_valid: got %b expected 0", valid_b); end
    tick();
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_ignored_start();
    test_rst_mid();
    test_refresh_stalls();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
